// File: rtl/alu_wb_pkg.sv
// Shared definitions for the ALU writeback sequencer: opcodes, FSM states,
// default widths and the single-result opcode classifier.
package alu_wb_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_REG_AW = 5;
  localparam int DEF_MEM_AW = 9;

  localparam logic [5:0] OP_MOV   = 6'd0;
  localparam logic [5:0] OP_MOVI  = 6'd1;
  localparam logic [5:0] OP_LOAD  = 6'd2;
  localparam logic [5:0] OP_STORE = 6'd3;
  localparam logic [5:0] OP_ADD   = 6'd4;
  localparam logic [5:0] OP_SUB   = 6'd5;
  localparam logic [5:0] OP_NEG   = 6'd6;
  localparam logic [5:0] OP_MUL   = 6'd7;
  localparam logic [5:0] OP_DIV   = 6'd8;
  localparam logic [5:0] OP_OR    = 6'd9;
  localparam logic [5:0] OP_XOR   = 6'd10;
  localparam logic [5:0] OP_NAND  = 6'd11;
  localparam logic [5:0] OP_NOR   = 6'd12;
  localparam logic [5:0] OP_XNOR  = 6'd13;
  localparam logic [5:0] OP_NOT   = 6'd14;
  localparam logic [5:0] OP_LLSH  = 6'd15;
  localparam logic [5:0] OP_LRSH  = 6'd16;

  typedef enum logic [1:0] {
    IDLE,
    MUL_HI,
    LD_REQ,
    LD_DATA
  } wb_state_t;

  // Ops that finish with exactly one register write from the result mux.
  function automatic logic is_single(input logic [5:0] op);
    return (op == OP_MOV) || (op == OP_MOVI) ||
           ((op >= OP_ADD) && (op <= OP_LRSH) && (op != OP_MUL));
  endfunction

endpackage

// File: rtl/wb_result_mux.sv
// Combinational opcode-to-result select for the single-result operations.
module wb_result_mux
  import alu_wb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [5:0]        opcode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] immediate,
  input  logic [DATA_W-1:0] sum,
  input  logic [DATA_W-1:0] diff,
  input  logic [DATA_W-1:0] negate,
  input  logic [DATA_W-1:0] divi,
  input  logic [DATA_W-1:0] or_r,
  input  logic [DATA_W-1:0] xor_r,
  input  logic [DATA_W-1:0] nand_r,
  input  logic [DATA_W-1:0] nor_r,
  input  logic [DATA_W-1:0] xnor_r,
  input  logic [DATA_W-1:0] not_r,
  input  logic [DATA_W-1:0] lsh_r,
  input  logic [DATA_W-1:0] rsh_r,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = '0;
    case (opcode)
      OP_MOV:  result = a;
      OP_MOVI: result = immediate;
      OP_ADD:  result = sum;
      OP_SUB:  result = diff;
      OP_NEG:  result = negate;
      OP_DIV:  result = divi;
      OP_OR:   result = or_r;
      OP_XOR:  result = xor_r;
      OP_NAND: result = nand_r;
      OP_NOR:  result = nor_r;
      OP_XNOR: result = xnor_r;
      OP_NOT:  result = not_r;
      OP_LLSH: result = lsh_r;
      OP_LRSH: result = rsh_r;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_writeback.sv
// Writeback sequencer: register-file and data-memory strobes for ALU results,
// two-beat MUL and three-beat LOAD. Define WB_FLAGS_EN for z_flag/n_flag.
module alu_writeback
  import alu_wb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW,
  parameter int MEM_AW = DEF_MEM_AW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [5:0]          opcode,
  input  logic [REG_AW-1:0]   rdst1,
  input  logic [REG_AW-1:0]   rdst2,
  input  logic [MEM_AW-1:0]   rsrc_add,
  input  logic [MEM_AW-1:0]   rdst_add,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   immediate,
  input  logic [DATA_W-1:0]   sum,
  input  logic [DATA_W-1:0]   diff,
  input  logic [DATA_W-1:0]   negate,
  input  logic [DATA_W-1:0]   divi,
  input  logic [DATA_W-1:0]   or_r,
  input  logic [DATA_W-1:0]   xor_r,
  input  logic [DATA_W-1:0]   nand_r,
  input  logic [DATA_W-1:0]   nor_r,
  input  logic [DATA_W-1:0]   xnor_r,
  input  logic [DATA_W-1:0]   not_r,
  input  logic [DATA_W-1:0]   lsh_r,
  input  logic [DATA_W-1:0]   rsh_r,
  input  logic [2*DATA_W-1:0] multiplied,
  output logic                wr_en,
  output logic [REG_AW-1:0]   wr_addr,
  output logic [DATA_W-1:0]   wr_data,
  output logic                mem_re,
  output logic                mem_we,
  output logic [MEM_AW-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                illegal
`ifdef WB_FLAGS_EN
  ,
  output logic                z_flag,
  output logic                n_flag
`endif
);

  wb_state_t         state;
  logic [REG_AW-1:0] pend_addr;
  logic [DATA_W-1:0] pend_data;
  logic [DATA_W-1:0] mux_result;

  wb_result_mux #(.DATA_W(DATA_W)) u_mux (
    .opcode(opcode), .a(a), .immediate(immediate), .sum(sum), .diff(diff),
    .negate(negate), .divi(divi), .or_r(or_r), .xor_r(xor_r), .nand_r(nand_r),
    .nor_r(nor_r), .xnor_r(xnor_r), .not_r(not_r), .lsh_r(lsh_r),
    .rsh_r(rsh_r), .result(mux_result)
  );

  assign in_ready = (state == IDLE);

  // pend_addr holds rdst2 for MUL high half or rdst1 for the LOAD write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      illegal   <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
    end else begin
      wr_en   <= 1'b0;
      mem_re  <= 1'b0;
      mem_we  <= 1'b0;
      illegal <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (opcode == OP_MUL) begin
              wr_en     <= 1'b1;
              wr_addr   <= rdst1;
              wr_data   <= multiplied[DATA_W-1:0];
              pend_addr <= rdst2;
              pend_data <= multiplied[2*DATA_W-1:DATA_W];
              state     <= MUL_HI;
            end else if (opcode == OP_LOAD) begin
              mem_re    <= 1'b1;
              mem_addr  <= rsrc_add;
              pend_addr <= rdst1;
              state     <= LD_REQ;
            end else if (opcode == OP_STORE) begin
              mem_we    <= 1'b1;
              mem_addr  <= rdst_add;
              mem_wdata <= a;
            end else if (is_single(opcode)) begin
              wr_en   <= 1'b1;
              wr_addr <= rdst1;
              wr_data <= mux_result;
            end else begin
              illegal <= 1'b1;
            end
          end
        end
        MUL_HI: begin
          wr_en   <= 1'b1;
          wr_addr <= pend_addr;
          wr_data <= pend_data;
          state   <= IDLE;
        end
        LD_REQ: state <= LD_DATA;
        LD_DATA: begin
          wr_en   <= 1'b1;
          wr_addr <= pend_addr;
          wr_data <= mem_rdata;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WB_FLAGS_EN
  logic              lo_zero;
  logic              flag_upd;
  logic              z_next;
  logic              n_next;

  // Flags track the value being written this cycle; MUL judges the full product.
  always_comb begin
    flag_upd = 1'b0;
    z_next   = 1'b0;
    n_next   = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && is_single(opcode)) begin
          flag_upd = 1'b1;
          z_next   = (mux_result == '0);
          n_next   = mux_result[DATA_W-1];
        end
      end
      MUL_HI: begin
        flag_upd = 1'b1;
        z_next   = lo_zero && (pend_data == '0);
        n_next   = pend_data[DATA_W-1];
      end
      LD_DATA: begin
        flag_upd = 1'b1;
        z_next   = (mem_rdata == '0);
        n_next   = mem_rdata[DATA_W-1];
      end
      default: flag_upd = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_zero <= 1'b0;
      z_flag  <= 1'b0;
      n_flag  <= 1'b0;
    end else begin
      if (state == IDLE && in_valid && opcode == OP_MUL)
        lo_zero <= (multiplied[DATA_W-1:0] == '0);
      if (flag_upd) begin
        z_flag <= z_next;
        n_flag <= n_next;
      end
    end
  end
`endif

endmodule
